// File: rtl/tft_rect_fill.sv
// Purpose : draws one solid RGB565 rectangle on an ILI9341-class TFT through the
//           shared byte-wide transmit interface: column window (0x2A), page window
//           (0x2B), memory write (0x2C), then w*h pixels, high colour byte first.
// Latency : first strobe 2 cycles after start; one byte per 2 cycles when the
//           serialiser is idle; done pulses 2 cycles after the last strobe
//           (2 cycles after start when w or h is zero).
// Backpressure: a strobe is only issued in a cycle where tft_busy=0; the fixed GAP
//           cycle after each strobe covers the serialiser's one-cycle busy latency.
// Optional: define TFT_RECT_BORDER_EN to add border_color; edge pixels use it.
// Ports   : clk, rst (sync, active-high); start + x/y/w/h/color request;
//           tft_busy in; tft_dc/tft_data/tft_transmit out; busy/done status.
module tft_rect_fill #(
   parameter int COORD_W  = 9,
   parameter int MAX_SIZE = 32,
   parameter int SIZE_W   = $clog2(MAX_SIZE + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [SIZE_W-1:0]  w,
   input  logic [SIZE_W-1:0]  h,
   input  logic [15:0]        color,
`ifdef TFT_RECT_BORDER_EN
   input  logic [15:0]        border_color,
`endif
   input  logic               tft_busy,
   output logic               tft_dc,
   output logic [7:0]         tft_data,
   output logic               tft_transmit,
   output logic               busy,
   output logic               done
);

   localparam int PIX_W = $clog2(MAX_SIZE * MAX_SIZE + 1);
   localparam logic [SIZE_W-1:0] MAX_S = SIZE_W'(MAX_SIZE);
   // Index 11 is the pixel stream; 0..10 are the window/command bytes.
   localparam logic [3:0] IDX_PIX = 4'd11;

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t      r_state;
   logic [15:0] r_xs, r_ys, r_xe, r_ye;
   logic [15:0] r_color;
   logic [3:0]  r_idx;
   logic        r_phase;   // 0 = colour high byte, 1 = low byte
   logic        r_tx, r_dc, r_busy, r_done;
   logic [7:0]  r_data;

   logic [SIZE_W-1:0] w_wc, w_hc;
   logic [15:0]       w_pix_color;
   logic              w_last_pix;
   logic [7:0]        w_byte;
   logic              w_dc;

   // Oversized requests are clamped rather than rejected.
   assign w_wc = (w > MAX_S) ? MAX_S : w;
   assign w_hc = (h > MAX_S) ? MAX_S : h;

`ifdef TFT_RECT_BORDER_EN
   logic [15:0]       r_bcolor;
   logic [SIZE_W-1:0] r_w, r_h, r_col, r_row;
   logic              w_edge;

   // Any pixel on the outer ring is border; w<=2 or h<=2 makes every pixel edge.
   assign w_edge = (r_row == '0) || (r_row == r_h - SIZE_W'(1)) ||
                   (r_col == '0) || (r_col == r_w - SIZE_W'(1));
   assign w_pix_color = w_edge ? r_bcolor : r_color;
   assign w_last_pix  = (r_row == r_h - SIZE_W'(1)) && (r_col == r_w - SIZE_W'(1));
`else
   logic [PIX_W-1:0] r_pix_cnt;
   logic [PIX_W-1:0] w_area;

   assign w_area      = PIX_W'(w_wc) * PIX_W'(w_hc);
   assign w_pix_color = r_color;
   assign w_last_pix  = (r_pix_cnt == PIX_W'(1));
`endif

   always_comb begin
      w_byte = 8'h00;
      w_dc   = 1'b1;
      case (r_idx)
         4'd0:    begin w_byte = 8'h2A; w_dc = 1'b0; end
         4'd1:    w_byte = r_xs[15:8];
         4'd2:    w_byte = r_xs[7:0];
         4'd3:    w_byte = r_xe[15:8];
         4'd4:    w_byte = r_xe[7:0];
         4'd5:    begin w_byte = 8'h2B; w_dc = 1'b0; end
         4'd6:    w_byte = r_ys[15:8];
         4'd7:    w_byte = r_ys[7:0];
         4'd8:    w_byte = r_ye[15:8];
         4'd9:    w_byte = r_ye[7:0];
         4'd10:   begin w_byte = 8'h2C; w_dc = 1'b0; end
         default: w_byte = r_phase ? w_pix_color[7:0] : w_pix_color[15:8];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_tx    <= 1'b0;
         r_dc    <= 1'b0;
         r_data  <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= 4'd0;
         r_phase <= 1'b0;
         r_xs    <= 16'h0;
         r_ys    <= 16'h0;
         r_xe    <= 16'h0;
         r_ye    <= 16'h0;
         r_color <= 16'h0;
`ifdef TFT_RECT_BORDER_EN
         r_bcolor <= 16'h0;
         r_w      <= '0;
         r_h      <= '0;
         r_col    <= '0;
         r_row    <= '0;
`else
         r_pix_cnt <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_tx   <= 1'b0;
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (start) begin
                  r_xs    <= 16'(x);
                  r_ys    <= 16'(y);
                  // 16-bit end coordinates; no wrap, clipping is the caller's job.
                  r_xe    <= 16'(x) + 16'(w_wc) - 16'd1;
                  r_ye    <= 16'(y) + 16'(h_wc_fix(w_hc)) - 16'd1;
                  r_color <= color;
                  r_idx   <= 4'd0;
                  r_phase <= 1'b0;
                  r_busy  <= 1'b1;
`ifdef TFT_RECT_BORDER_EN
                  r_bcolor <= border_color;
                  r_w      <= w_wc;
                  r_h      <= w_hc;
                  r_col    <= '0;
                  r_row    <= '0;
`else
                  r_pix_cnt <= w_area;
`endif
                  r_state <= ((w_wc == '0) || (w_hc == '0)) ? DONE : SEND;
               end
            end
            SEND: begin
               if (!tft_busy) begin
                  r_tx    <= 1'b1;
                  r_data  <= w_byte;
                  r_dc    <= w_dc;
                  r_state <= GAP;
               end else begin
                  r_tx <= 1'b0;
               end
            end
            GAP: begin
               r_tx    <= 1'b0;
               r_state <= SEND;
               if (r_idx != IDX_PIX) begin
                  r_idx <= r_idx + 4'd1;
               end else if (!r_phase) begin
                  r_phase <= 1'b1;
               end else begin
                  r_phase <= 1'b0;
                  if (w_last_pix) begin
                     r_state <= DONE;
                  end else begin
`ifdef TFT_RECT_BORDER_EN
                     if (r_col == r_w - SIZE_W'(1)) begin
                        r_col <= '0;
                        r_row <= r_row + SIZE_W'(1);
                     end else begin
                        r_col <= r_col + SIZE_W'(1);
                     end
`else
                     r_pix_cnt <= r_pix_cnt - PIX_W'(1);
`endif
                  end
               end
            end
            DONE: begin
               // done is registered, so it shows in the first IDLE cycle with busy
               // still high; busy falls one cycle later.
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   function automatic logic [SIZE_W-1:0] h_wc_fix(input logic [SIZE_W-1:0] v);
      return v;
   endfunction

   assign tft_transmit = r_tx;
   assign tft_dc       = r_dc;
   assign tft_data     = r_data;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_tft_rect_fill.sv
// Scoreboard bench for tft_rect_fill: directed rectangles push hand-computed
// {dc,byte} sequences into a queue; a monitor pops and compares on every strobe.
module tb_tft_rect_fill;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [8:0] x = '0, y = '0;
   logic [5:0] w = '0, h = '0;
   logic [15:0] color = '0;
`ifdef TFT_RECT_BORDER_EN
   logic [15:0] border_color = '0;
`endif
   logic       tft_busy = 1'b0;
   logic       tft_dc, tft_transmit, busy, done;
   logic [7:0] tft_data;

   tft_rect_fill #(.COORD_W(9), .MAX_SIZE(32)) dut (
      .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .w(w), .h(h),
      .color(color),
`ifdef TFT_RECT_BORDER_EN
      .border_color(border_color),
`endif
      .tft_busy(tft_busy), .tft_dc(tft_dc), .tft_data(tft_data),
      .tft_transmit(tft_transmit), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   logic [8:0] exp_q[$];
   int  strobe_cnt = 0;
   int  cyc = 0;
   int  last_cyc = 0;
   int  stall_left = 0;
   bit  stall_en = 1'b0;
   bit  chk_gap = 1'b1;
   logic prev_tx = 1'b0;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Header bytes MSB first; indices 0, 5 and 10 are commands (dc=0).
   task automatic push_hdr(input logic [87:0] hv);
      for (int i = 0; i < 11; i++)
         exp_q.push_back({(i != 0 && i != 5 && i != 10), hv[87-8*i -: 8]});
   endtask

   task automatic push_pix(input int n, input logic [15:0] c);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'b1, c[15:8]});
         exp_q.push_back({1'b1, c[7:0]});
      end
   endtask

   // Monitor: scoreboard compare, strobe spacing, and optional serialiser stall.
   always @(negedge clk) begin
      logic [8:0] e;
      cyc++;
      if (tft_transmit) begin
         if (stall_en) chk_eq("strobe_while_busy", tft_busy, 0);
         chk_eq("back_to_back_strobe", prev_tx, 0);
         if (chk_gap && strobe_cnt > 0) chk_eq("strobe_spacing", cyc - last_cyc, 2);
         if (exp_q.size() == 0) begin
            chk_eq("unexpected_strobe", {tft_dc, tft_data}, 9'h000);
         end else begin
            e = exp_q.pop_front();
            chk_eq("byte", {tft_dc, tft_data}, e);
         end
         strobe_cnt++;
         last_cyc = cyc;
         if (stall_en) stall_left = 5;
      end
      tft_busy = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      prev_tx = tft_transmit;
   end

   task automatic run_rect(input logic [8:0] rx, input logic [8:0] ry,
                           input logic [5:0] rw, input logic [5:0] rh,
                           input logic [15:0] rc, input int nstb,
                           input int exp_lat, input bit poke);
      int lat;
      lat = 0;
      x = rx; y = ry; w = rw; h = rh; color = rc;
      strobe_cnt = 0;
      start = 1'b1;
      while (lat < 5000) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            chk_eq("busy_after_start", busy, 1);
         end
         if (poke && lat == 6) begin
            start = 1'b1; x = 9'h1FF; y = 9'h1FF; w = 6'd7; color = 16'hAAAA;
         end
         if (poke && lat == 7) start = 1'b0;
         if (done) break;
      end
      chk_eq("done_seen", done, 1);
      if (exp_lat >= 0) chk_eq("done_latency", lat, exp_lat);
      chk_eq("strobe_count", strobe_cnt, nstb);
      chk_eq("queue_drained", exp_q.size(), 0);
      @(negedge clk);
      chk_eq("busy_drop", busy, 0);
      chk_eq("done_single", done, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_eq("rst_transmit", tft_transmit, 0);
      chk_eq("rst_dc", tft_dc, 0);
      chk_eq("rst_data", tft_data, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      // 2x3 red at (10,20): xe=11, ye=22.
      push_hdr(88'h2A_00_0A_00_0B_2B_00_14_00_16_2C);
      push_pix(6, 16'hF800);
      run_rect(9'd10, 9'd20, 6'd2, 6'd3, 16'hF800, 23, 48, 1'b0);

      // 32x1 at (300,0): xe=331=0x14B; mid-run start/x changes must be ignored.
      push_hdr(88'h2A_01_2C_01_4B_2B_00_00_00_00_2C);
      push_pix(32, 16'h1234);
      run_rect(9'd300, 9'd0, 6'd32, 6'd1, 16'h1234, 75, 152, 1'b1);

      // Zero width: nothing sent, done two cycles after start.
      run_rect(9'd4, 9'd4, 6'd0, 6'd5, 16'hFFFF, 0, 2, 1'b0);

      // Width 40 clamps to 32: xe = 3+31 = 34.
      push_hdr(88'h2A_00_03_00_22_2B_00_04_00_04_2C);
      push_pix(32, 16'h07E0);
      run_rect(9'd3, 9'd4, 6'd40, 6'd1, 16'h07E0, 75, 152, 1'b0);

      // Serialiser stalls 5 cycles after every strobe.
      stall_en = 1'b1; chk_gap = 1'b0;
      push_hdr(88'h2A_00_05_00_06_2B_00_07_00_08_2C);
      push_pix(4, 16'hBEEF);
      run_rect(9'd5, 9'd7, 6'd2, 6'd2, 16'hBEEF, 19, -1, 1'b0);
      repeat (6) @(negedge clk);
      stall_en = 1'b0; chk_gap = 1'b1;

      // Reset after the 4th strobe aborts; rerun replays from 0x2A.
      push_hdr(88'h2A_00_0A_00_0B_2B_00_14_00_16_2C);
      push_pix(6, 16'hF800);
      x = 9'd10; y = 9'd20; w = 6'd2; h = 6'd3; color = 16'hF800;
      strobe_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (strobe_cnt >= 4) break;
      end
      chk_eq("strobes_before_reset", strobe_cnt, 4);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk_eq("abort_transmit", tft_transmit, 0);
      chk_eq("abort_busy", busy, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("no_strobe_after_abort", strobe_cnt, 4);
      push_hdr(88'h2A_00_0A_00_0B_2B_00_14_00_16_2C);
      push_pix(6, 16'hF800);
      run_rect(9'd10, 9'd20, 6'd2, 6'd3, 16'hF800, 23, 48, 1'b0);

`ifdef TFT_RECT_BORDER_EN
      // 3x3: only the centre pixel (index 4) uses the fill colour.
      border_color = 16'h001F;
      push_hdr(88'h2A_00_00_00_02_2B_00_00_00_02_2C);
      push_pix(4, 16'h001F);
      push_pix(1, 16'h07E0);
      push_pix(4, 16'h001F);
      run_rect(9'd0, 9'd0, 6'd3, 6'd3, 16'h07E0, 29, 60, 1'b0);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
